// File: rtl/systolic_array_ws_seq_if.sv
// systolic_array_ws_seq_if: weight/activation handshakes and result bundle for the WS array
interface systolic_array_ws_seq_if #(
  parameter int WORDWIDTH = 8,
  parameter int ARRHEIGHT = 4,
  parameter int ARRWIDTH  = 4,
  parameter int PSWIDTH   = 32
);
  logic                            w_valid;
  logic                            w_ready;
  logic [WORDWIDTH*ARRWIDTH-1:0]   w_in_vec;
  logic                            a_valid;
  logic                            a_ready;
  logic                            a_last;
  logic [WORDWIDTH*ARRHEIGHT-1:0]  a_in_vec;
  logic                            ps_valid;
  logic [PSWIDTH*ARRWIDTH-1:0]     ps_out_vec;
  logic                            busy;
  modport master (
    output w_valid, w_in_vec, a_valid, a_last, a_in_vec,
    input  w_ready, a_ready, ps_valid, ps_out_vec, busy
  );
  modport slave (
    input  w_valid, w_in_vec, a_valid, a_last, a_in_vec,
    output w_ready, a_ready, ps_valid, ps_out_vec, busy
  );
endinterface

// File: rtl/systolic_array_ws_seq.sv
// systolic_array_ws_seq: weight-stationary systolic array with load/compute sequencer, input skew and output deskew
module systolic_array_ws_seq #(
  parameter int WORDWIDTH = 8,
  parameter int ARRHEIGHT = 4,
  parameter int ARRWIDTH  = 4,
  parameter int PSWIDTH   = 32
) (
  input logic clk,
  input logic reset,
  systolic_array_ws_seq_if.slave bus
);
  localparam int LAT = ARRHEIGHT + ARRWIDTH;
  localparam int CW  = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic w_ready, a_ready, w_fire, a_fire;
  logic signed [WORDWIDTH-1:0]   w_q  [ARRHEIGHT][ARRWIDTH];
  logic signed [WORDWIDTH-1:0]   w_d  [ARRHEIGHT][ARRWIDTH];
  logic signed [WORDWIDTH-1:0]   act  [ARRHEIGHT][ARRWIDTH];
  logic signed [2*WORDWIDTH-1:0] prod [ARRHEIGHT][ARRWIDTH];
  logic signed [PSWIDTH-1:0]     ps_q [ARRHEIGHT][ARRWIDTH];
  logic signed [PSWIDTH-1:0]     ps_d [ARRHEIGHT][ARRWIDTH];
  logic signed [PSWIDTH-1:0]     col  [ARRWIDTH];
  logic [LAT-1:0] v_q, v_d;
  logic ps_valid_q, ps_valid_d;
  logic [PSWIDTH*ARRWIDTH-1:0] ps_out_q, ps_out_d;

  assign w_ready        = (state_q == IDLE) || (state_q == LOAD);
  assign a_ready        = state_q == COMPUTE;
  assign w_fire         = bus.w_valid && w_ready;
  assign a_fire         = bus.a_valid && a_ready;
  assign bus.w_ready    = w_ready;
  assign bus.a_ready    = a_ready;
  assign bus.busy       = state_q != IDLE;
  assign bus.ps_valid   = ps_valid_q;
  assign bus.ps_out_vec = ps_out_q;

  // sequencer: counter tracks the weight row being loaded, then the drain countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, LOAD: if (w_fire) begin
        state_d = (cnt_q == CW'(ARRHEIGHT - 1)) ? COMPUTE : LOAD;
        cnt_d   = (cnt_q == CW'(ARRHEIGHT - 1)) ? '0 : cnt_q + 1'b1;
      end
      COMPUTE: if (a_fire && bus.a_last) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: begin
        state_d = (cnt_q == CW'(LAT - 1)) ? IDLE : DRAIN;
        cnt_d   = (cnt_q == CW'(LAT - 1)) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // an accepted weight beat overwrites the row selected by the counter
  always_comb begin
    w_d = w_q;
    for (int k = 0; k < ARRHEIGHT; k++)
      for (int j = 0; j < ARRWIDTH; j++)
        if (w_fire && cnt_q == CW'(k)) w_d[k][j] = bus.w_in_vec[j*WORDWIDTH +: WORDWIDTH];
  end

  // PE grid: products sign-extend, partial sums flow down each column and wrap
  always_comb begin
    for (int k = 0; k < ARRHEIGHT; k++)
      for (int j = 0; j < ARRWIDTH; j++)
        prod[k][j] = (2*WORDWIDTH)'(act[k][j]) * (2*WORDWIDTH)'(w_q[k][j]);
    for (int j = 0; j < ARRWIDTH; j++)
      ps_d[0][j] = PSWIDTH'(prod[0][j]);
    for (int k = 1; k < ARRHEIGHT; k++)
      for (int j = 0; j < ARRWIDTH; j++)
        ps_d[k][j] = ps_q[k-1][j] + PSWIDTH'(prod[k][j]);
  end

  // each row's activation chain: first k stages are input skew, the rest feed the PEs left to right
  for (genvar k = 0; k < ARRHEIGHT; k++) begin : g_row
    logic signed [WORDWIDTH-1:0] sh_q [k+ARRWIDTH];
    logic signed [WORDWIDTH-1:0] sh_d [k+ARRWIDTH];
    // bubbles shift in as zero
    always_comb begin
      sh_d[0] = a_fire ? bus.a_in_vec[k*WORDWIDTH +: WORDWIDTH] : '0;
      for (int i = 1; i < k + ARRWIDTH; i++) sh_d[i] = sh_q[i-1];
    end
    // row shift register
    always_ff @(posedge clk or posedge reset)
      if (reset) sh_q <= '{default: '0};
      else sh_q <= sh_d;
    for (genvar j = 0; j < ARRWIDTH; j++) begin : g_tap
      assign act[k][j] = sh_q[k+j];
    end
  end

  // column deskew: column j waits ARRWIDTH-1-j extra cycles so all lanes align
  for (genvar j = 0; j < ARRWIDTH; j++) begin : g_col
    if (j < ARRWIDTH - 1) begin : g_dly
      logic signed [PSWIDTH-1:0] dk_q [ARRWIDTH-1-j];
      logic signed [PSWIDTH-1:0] dk_d [ARRWIDTH-1-j];
      // deskew shift
      always_comb begin
        dk_d[0] = ps_q[ARRHEIGHT-1][j];
        for (int i = 1; i < ARRWIDTH - 1 - j; i++) dk_d[i] = dk_q[i-1];
      end
      // deskew register
      always_ff @(posedge clk or posedge reset)
        if (reset) dk_q <= '{default: '0};
        else dk_q <= dk_d;
      assign col[j] = dk_q[ARRWIDTH-2-j];
    end else begin : g_thru
      assign col[j] = ps_q[ARRHEIGHT-1][j];
    end
  end

  // valid tag travels alongside the data; output register holds between results
  always_comb begin
    v_d        = {v_q[LAT-2:0], a_fire};
    ps_valid_d = v_q[LAT-1];
    ps_out_d   = ps_out_q;
    for (int j = 0; j < ARRWIDTH; j++)
      ps_out_d[j*PSWIDTH +: PSWIDTH] = v_q[LAT-1] ? col[j] : ps_out_q[j*PSWIDTH +: PSWIDTH];
  end

  // state, weights, partial sums and output registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      w_q        <= '{default: '0};
      ps_q       <= '{default: '0};
      v_q        <= '0;
      ps_valid_q <= 1'b0;
      ps_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_q        <= w_d;
      ps_q       <= ps_d;
      v_q        <= v_d;
      ps_valid_q <= ps_valid_d;
      ps_out_q   <= ps_out_d;
    end
endmodule

// File: tb/tb_systolic_array_ws_seq.sv
// tb_systolic_array_ws_seq: directed checks of load/compute sequencing, latency, wrap and reset
module tb_systolic_array_ws_seq;
  localparam int LAT = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic w_valid, a_valid, a_last;
  logic [31:0] w_in, a_in;
  logic [127:0] a_exp;
  logic c_w_valid, c_a_valid, c_a_last;
  logic [23:0] c_w_in;
  logic [15:0] c_a_in;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int due_q[$];
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  systolic_array_ws_seq_if ifa();
  systolic_array_ws_seq_if #(.PSWIDTH(16)) ifb();
  systolic_array_ws_seq_if #(.ARRHEIGHT(2), .ARRWIDTH(3)) ifc();

  assign ifa.w_valid = w_valid;
  assign ifa.w_in_vec = w_in;
  assign ifa.a_valid = a_valid;
  assign ifa.a_last = a_last;
  assign ifa.a_in_vec = a_in;
  assign ifb.w_valid = w_valid;
  assign ifb.w_in_vec = w_in;
  assign ifb.a_valid = a_valid;
  assign ifb.a_last = a_last;
  assign ifb.a_in_vec = a_in;
  assign ifc.w_valid = c_w_valid;
  assign ifc.w_in_vec = c_w_in;
  assign ifc.a_valid = c_a_valid;
  assign ifc.a_last = c_a_last;
  assign ifc.a_in_vec = c_a_in;

  systolic_array_ws_seq u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  systolic_array_ws_seq #(.PSWIDTH(16)) u_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  systolic_array_ws_seq #(.ARRHEIGHT(2), .ARRWIDTH(3)) u_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [127:0] pv4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] tr16(input logic [127:0] v);
    return {v[111:96], v[79:64], v[47:32], v[15:0]};
  endfunction

  // scoreboard: every accepted beat is owed one result LAT edges later, and nothing else may pulse
  always @(negedge clk) begin
    if (reset) begin
      due_q.delete();
      exp_q.delete();
    end else begin
      automatic logic want = due_q.size() > 0 && due_q[0] == cyc;
      chk("ps_valid", ifa.ps_valid, want);
      chk("ps16 ps_valid", ifb.ps_valid, want);
      if (want) begin
        chk("ps_out", ifa.ps_out_vec, exp_q[0]);
        chk("ps16 ps_out", ifb.ps_out_vec, tr16(exp_q[0]));
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (a_valid && ifa.a_ready) begin
        due_q.push_back(cyc + LAT + 1);
        exp_q.push_back(a_exp);
      end
    end
    cyc++;
  end

  task automatic wbeat(input logic [31:0] row, input int gap);
    repeat (gap) begin
      w_valid = 1'b0;
      chk("load gap a_ready", ifa.a_ready, 0);
      @(posedge clk); #1;
    end
    w_valid = 1'b1;
    w_in = row;
    chk("load w_ready", ifa.w_ready, 1);
    chk("load a_ready", ifa.a_ready, 0);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic abeat(input logic [31:0] x, input logic [127:0] y, input logic last, input int gap);
    repeat (gap) begin
      a_valid = 1'b0;
      @(posedge clk); #1;
    end
    a_valid = 1'b1;
    a_in = x;
    a_exp = y;
    a_last = last;
    chk("comp a_ready", ifa.a_ready, 1);
    chk("comp w_ready", ifa.w_ready, 0);
    chk("comp busy", ifa.busy, 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    automatic int m;
    w_valid = 0; w_in = 0; a_valid = 0; a_last = 0; a_in = 0; a_exp = 0;
    c_w_valid = 0; c_w_in = 0; c_a_valid = 0; c_a_last = 0; c_a_in = 0;
    #12;
    chk("rst ps_valid", ifa.ps_valid, 0);
    chk("rst ps_out", ifa.ps_out_vec, 0);
    chk("rst busy", ifa.busy, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("idle w_ready", ifa.w_ready, 1);
    chk("idle a_ready", ifa.a_ready, 0);
    // identity weights, back-to-back beats
    wbeat(pk4(1, 0, 0, 0), 0);
    wbeat(pk4(0, 1, 0, 0), 0);
    wbeat(pk4(0, 0, 1, 0), 0);
    wbeat(pk4(0, 0, 0, 1), 0);
    abeat(pk4(1, 2, 3, 4), pv4(1, 2, 3, 4), 0, 0);
    abeat(pk4(-5, 6, -7, 8), pv4(-5, 6, -7, 8), 1, 0);
    repeat (7) @(posedge clk);
    #1 chk("busy in drain", ifa.busy, 1);
    @(posedge clk);
    #1 chk("busy after drain", ifa.busy, 0);
    repeat (2) @(posedge clk);
    #1 chk("ps_out hold", ifa.ps_out_vec, pv4(-5, 6, -7, 8));
    // mixed weights
    wbeat(pk4(1, 2, 3, 4), 0);
    wbeat(pk4(4, 3, 2, 1), 0);
    wbeat(pk4(1, 2, 3, 4), 0);
    wbeat(pk4(4, 3, 2, 1), 0);
    abeat(pk4(1, 2, 3, 4), pv4(28, 26, 24, 22), 0, 0);
    abeat(pk4(4, 3, 2, 1), pv4(22, 24, 26, 28), 1, 0);
    repeat (LAT + 2) @(posedge clk); #1;
    // gaps, stray a_valid during load, stray w_valid during compute
    a_valid = 1'b1; a_last = 1'b1; a_in = pk4(7, 7, 7, 7); a_exp = pv4(-1, -1, -1, -1);
    wbeat(pk4(1, 1, 1, 1), 1);
    wbeat(pk4(1, -1, 1, -1), 0);
    wbeat(pk4(2, 0, 0, 0), 2);
    a_valid = 1'b0; a_last = 1'b0;
    wbeat(pk4(0, 0, 0, -2), 1);
    w_valid = 1'b1; w_in = pk4(9, 9, 9, 9);
    abeat(pk4(1, 2, 3, 4), pv4(9, -1, 3, -9), 0, 0);
    abeat(pk4(3, 0, -1, 1), pv4(1, 3, 3, 1), 0, 2);
    abeat(pk4(0, 5, 0, 0), pv4(5, -5, 5, -5), 1, 1);
    w_valid = 1'b0;
    repeat (LAT + 2) @(posedge clk); #1;
    // wrap at 16 bits
    repeat (4) wbeat(pk4(-128, -128, -128, -128), 0);
    abeat(pk4(-128, -128, -128, -128), pv4(65536, 65536, 65536, 65536), 0, 0);
    abeat(pk4(-128, -128, -128, 0), pv4(49152, 49152, 49152, 49152), 1, 0);
    repeat (LAT + 2) @(posedge clk); #1;
    // reset with two beats in flight
    repeat (4) wbeat(pk4(1, 1, 1, 1), 0);
    abeat(pk4(1, 1, 1, 1), pv4(4, 4, 4, 4), 0, 0);
    abeat(pk4(2, 2, 2, 2), pv4(8, 8, 8, 8), 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst ps_valid", ifa.ps_valid, 0);
    chk("midrst ps_out", ifa.ps_out_vec, 0);
    chk("midrst w_ready", ifa.w_ready, 1);
    chk("midrst a_ready", ifa.a_ready, 0);
    chk("midrst busy", ifa.busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post rst busy", ifa.busy, 0);
    wbeat(pk4(1, 2, 3, 4), 0);
    wbeat(pk4(4, 3, 2, 1), 0);
    wbeat(pk4(1, 2, 3, 4), 0);
    wbeat(pk4(4, 3, 2, 1), 0);
    abeat(pk4(4, 3, 2, 1), pv4(22, 24, 26, 28), 1, 0);
    repeat (LAT + 4) @(posedge clk); #1;
    chk("pending results", due_q.size(), 0);
    // 2x3 array, latency 5
    c_w_valid = 1'b1; c_w_in = {8'd3, 8'd2, 8'd1};
    chk("c w_ready", ifc.w_ready, 1);
    @(posedge clk); #1;
    c_w_in = {8'd6, 8'd5, 8'd4};
    @(posedge clk); #1;
    c_w_valid = 1'b0;
    chk("c a_ready", ifc.a_ready, 1);
    c_a_valid = 1'b1; c_a_last = 1'b1; c_a_in = 16'h0101;
    @(posedge clk); #1;
    c_a_valid = 1'b0; c_a_last = 1'b0;
    m = 0;
    while (m < 20) begin
      @(negedge clk);
      if (ifc.ps_valid) break;
      m++;
    end
    chk("c latency", m, 5);
    chk("c ps_out", ifc.ps_out_vec, {32'd9, 32'd7, 32'd5});
    chk("c busy", ifc.busy, 0);
    @(negedge clk);
    chk("c single pulse", ifc.ps_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_array_ws_seq.md
Name: systolic_array_ws_seq

Overview:
Parametrised weight-stationary systolic array with a built-in load/compute sequencer, input skew and output deskew. It replaces the externally mode-driven WS array. A valid/ready handshake loads one weight row per beat. Activation vectors then stream in with a valid/ready handshake and a last marker. Column-aligned partial-sum vectors come out with a fixed latency, so no external skewing is needed. It sits between the activation/weight buffers and the accumulator stage.

Parameters:
WORDWIDTH, 8, signed width of each weight and activation lane
ARRHEIGHT, 4, PE rows; number of activation lanes and weight rows
ARRWIDTH, 4, PE columns; number of weight/output lanes
PSWIDTH, 32, signed partial-sum width per output lane; must be >= 2*WORDWIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat accepted when w_valid&w_ready
w_in_vec  in  WORDWIDTH*ARRWIDTH  one weight row; lane j at [j*WORDWIDTH +: WORDWIDTH]
a_valid  in  1  activation beat valid
a_ready  out  1  activation beat accepted when a_valid&a_ready
a_last  in  1  qualifies the final activation beat of a tile
a_in_vec  in  WORDWIDTH*ARRHEIGHT  activation vector; lane k at [k*WORDWIDTH +: WORDWIDTH]
ps_valid  out  1  ps_out_vec holds one result vector this cycle
ps_out_vec  out  PSWIDTH*ARRWIDTH  result; lane j at [j*PSWIDTH +: PSWIDTH]
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state) does all of the following:
  - state=IDLE, weight row counter=0, all PE weights=0.
  - All skew, pipeline and deskew registers cleared.
  - ps_valid=0, ps_out_vec=0, busy=0.
  - w_ready=1 and a_ready=0 from the first cycle after reset deassertion.
  - In-flight results are discarded and are never emitted.
- The FSM has four states: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE: w_ready=1, a_ready=0.
  - An accepted weight beat writes row 0 and sets the counter to 1.
  - Next state is LOAD, or COMPUTE if ARRHEIGHT=1.
- LOAD: w_ready=1, a_ready=0.
  - Accepted beat k writes row k (weight W[k][j]).
  - After the beat that writes row ARRHEIGHT-1, next state is COMPUTE and the counter returns to 0.
  - Cycles with w_valid=0 hold state.
- COMPUTE: w_ready=0, a_ready=1.
  - Each accepted beat x enters the pipeline.
  - Cycles with no accepted beat insert bubbles.
  - A beat accepted with a_last=1 moves the FSM to DRAIN.
- DRAIN: w_ready=0, a_ready=0.
  - Lasts exactly LAT=ARRHEIGHT+ARRWIDTH cycles, then IDLE.
  - The last result has been emitted by the time IDLE is entered.
  - Weights are retained but are fully overwritten by the next load.
- Inputs are ignored in states where the matching ready is 0:
  - a_valid in IDLE/LOAD/DRAIN.
  - w_valid in COMPUTE/DRAIN.
  - a_last when a_valid&a_ready=0.
- Arithmetic: y[j] = sum over k of x[k]*W[k][j].
  - Operands are signed two's complement.
  - Products are sign-extended to PSWIDTH.
  - Accumulation wraps modulo 2^PSWIDTH; there is no saturation.
- Latency: a beat accepted at rising edge t gives ps_valid=1 with y on ps_out_vec in the cycle following edge t+LAT.
  - All ARRWIDTH lanes of a vector appear in the same cycle.
  - Gaps between accepted beats are preserved in ps_valid.
  - Back-to-back beats give back-to-back results (throughput 1 vector/cycle).
- ps_out_vec holds its last value while ps_valid=0.
- There is no output backpressure; the consumer must always accept.
- Simultaneous events:
  - w_valid and a_valid together: only the handshake valid for the current state fires.
  - a_last on the first COMPUTE beat gives a one-vector tile.

Test Plan:
- Identity load, 4x4 default parameters.
  - Stimulus: weights W[k][j]=(k==j); then stream x=[1,2,3,4], x=[-5,6,-7,8] back-to-back, with a_last on the second beat.
  - Required: ps_out=[1,2,3,4] then [-5,6,-7,8] on consecutive cycles, 8 cycles after each acceptance.
  - Required: busy falls 8 cycles after the last acceptance.
- Mixed weights.
  - Stimulus: rows [1,2,3,4], [4,3,2,1], [1,2,3,4], [4,3,2,1]; stream x=[1,2,3,4] then [4,3,2,1].
  - Required: ps_out=[28,26,24,22] then [22,24,26,28].
- Handshake gaps and ignored inputs.
  - Stimulus: toggle w_valid during the load and a_valid during compute; drive a_valid during LOAD.
  - Required: only accepted beats count; ps_valid pattern equals the input acceptance pattern delayed by 8; a_ready stays 0 until the 4th weight beat is accepted.
- Overflow wrap with PSWIDTH=16.
  - Stimulus: all weights -128, x=[-128,-128,-128,-128].
  - Required: every lane = 0 (65536 mod 2^16).
  - Stimulus: x=[-128,-128,-128,0].
  - Required: every lane = -16384 (49152 mod 2^16).
- Reset mid-compute.
  - Stimulus: assert reset 3 cycles after accepting 2 beats, then release.
  - Required: ps_valid=0 immediately and never pulses for the flushed beats; w_ready=1, busy=0.
  - Required: reloading the weights gives correct results.
- Non-square array, ARRHEIGHT=2, ARRWIDTH=3.
  - Stimulus: rows [1,2,3], [4,5,6]; x=[1,1].
  - Required: ps_out=[5,7,9] with LAT=5.
